// File: rtl/mul16_seq_ctrl_pkg.sv
// mul_seq_pkg: shared states, widths and step-to-shift lookup for the sequenced 16x16 multiplier.
package mul_seq_pkg;
    localparam int STEP_W = 2;
    localparam int OP_W = 16;
    localparam int CORE_W = 8;
    localparam int ACC_W = 32;
    typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_e;
    function automatic logic [4:0] step_shift(input logic [STEP_W-1:0] step);
        return step == 2'd0 ? 5'd0 : step == 2'd3 ? 5'd16 : 5'd8;
    endfunction
endpackage

// File: rtl/mul16_seq_ctrl_if.sv
// mul16_seq_ctrl_if: operand/product valid-ready handshake plus flush and busy.
interface mul16_seq_ctrl_if;
    import mul_seq_pkg::*;
    logic flush;
    logic in_valid;
    logic in_ready;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic out_valid;
    logic out_ready;
    logic [ACC_W-1:0] product;
    logic busy;
    modport master (
        output flush, in_valid, a, b, out_ready,
        input in_ready, out_valid, product, busy
    );
    modport slave (
        input flush, in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mul16_seq_ctrl_core.sv
// mul16_seq_ctrl_core: combinational 8x8 unsigned exact multiplier.
module mul16_seq_ctrl_core
    import mul_seq_pkg::*;
(
    input  logic [CORE_W-1:0]   x,
    input  logic [CORE_W-1:0]   y,
    output logic [2*CORE_W-1:0] p
);
    assign p = x * y;
endmodule

// File: rtl/mul16_seq_ctrl.sv
// mul16_seq_ctrl: 16x16 unsigned multiply built from four LL/LH/HL/HH passes through one 8x8 core.
module mul16_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int PIPE_MUL = 0
) (
    input logic clk,
    input logic rst_n,
    mul16_seq_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MUL = MUL;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE = DONE;
    logic [1:0] state;
    logic [STEP_W-1:0] step;
    logic [ACC_W-1:0] acc;
    logic [OP_W-1:0] a_q, b_q;
    logic [CORE_W-1:0] op_a, op_b;
    logic [2*CORE_W-1:0] pp, pp_q, add_pp;
    logic [4:0] sh_q, add_sh;
    logic pv_q, add_en;
    always_comb begin
        op_a = step[1] ? a_q[15:8] : a_q[7:0];
        op_b = step[0] ? b_q[15:8] : b_q[7:0];
        add_pp = PIPE_MUL != 0 ? pp_q : pp;
        add_sh = PIPE_MUL != 0 ? sh_q : step_shift(step);
        add_en = PIPE_MUL != 0 ? pv_q : state == S_MUL;
    end
    mul16_seq_ctrl_core u_core (
        .x(op_a),
        .y(op_b),
        .p(pp)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            step <= '0;
            acc <= '0;
            a_q <= '0;
            b_q <= '0;
            pp_q <= '0;
            sh_q <= '0;
            pv_q <= 1'b0;
        end else if (bus.flush) begin
            state <= S_IDLE;
            step <= '0;
            acc <= '0;
            pv_q <= 1'b0;
        end else begin
            if (add_en)
                acc <= acc + (ACC_W'(add_pp) << add_sh);
            // the pipe slot captures every issued step; accumulation trails by one edge
            pv_q <= state == S_MUL;
            pp_q <= pp;
            sh_q <= step_shift(step);
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    a_q <= bus.a;
                    b_q <= bus.b;
                    acc <= '0;
                    step <= '0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    step <= step + 2'd1;
                    if (step == 2'd3)
                        state <= PIPE_MUL != 0 ? S_DRAIN : S_DONE;
                end
                S_DRAIN: state <= S_DONE;
                default: if (bus.out_ready) state <= S_IDLE;
            endcase
        end
    end
    assign bus.in_ready = rst_n && state == S_IDLE;
    assign bus.out_valid = state == S_DONE;
    assign bus.product = bus.out_valid ? acc : '0;
    assign bus.busy = state != S_IDLE;
endmodule
